// File: rtl/rsa_uart_wrapper.sv
// rsa_uart_wrapper: Avalon-MM master that feeds key/ciphertext bytes from the UART to the RSA core
// and streams the 248-bit plaintext back out, one polled byte at a time.
module rsa_uart_wrapper #(
  parameter int RX_BASE     = 0,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int RX_OK_BIT   = 7,
  parameter int TX_OK_BIT   = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);
  typedef enum logic [2:0] {S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND} state_t;
  state_t r_state, w_next;
  logic         r_data_ph;
  logic [4:0]   r_cnt;
  logic [247:0] r_out;
  logic w_rx, w_tx, w_done, w_ok, w_last, w_byte_last, w_issue, w_unused;
  assign w_rx        = r_state inside {S_GET_N, S_GET_D, S_GET_A};
  assign w_tx        = r_state == S_SEND;
  assign w_done      = (avm_read | avm_write) & ~avm_waitrequest;
  assign w_ok        = w_rx ? avm_readdata[RX_OK_BIT] : avm_readdata[TX_OK_BIT];
  assign w_last      = r_cnt == (w_rx ? 5'd31 : 5'd30);
  assign w_byte_last = w_done & r_data_ph & w_last;
  assign w_issue     = (w_rx | w_tx) & ~avm_read & ~avm_write;
  assign o_core_start = r_state == S_START;
  assign w_unused    = &{1'b0, avm_readdata[31:8], i_core_result[255:248]};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_GET_N;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_GET_N: w_next = w_byte_last ? S_GET_D : S_GET_N;
      S_GET_D: w_next = w_byte_last ? S_GET_A : S_GET_D;
      S_GET_A: w_next = w_byte_last ? S_START : S_GET_A;
      S_START: w_next = S_WAIT;
      S_WAIT:  w_next = i_core_finished ? S_SEND : S_WAIT;
      S_SEND:  w_next = w_byte_last ? S_GET_A : S_SEND;
      default: w_next = S_GET_N;
    endcase
  end
  // A completed transfer always drops the request, giving the mandatory idle cycle before the next one.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      avm_address   <= 5'(STATUS_BASE);
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= 32'h0;
      o_core_a      <= '0;
      o_core_d      <= '0;
      o_core_n      <= '0;
      r_out         <= '0;
      r_cnt         <= 5'd0;
      r_data_ph     <= 1'b0;
    end else if (w_done) begin
      avm_read  <= 1'b0;
      avm_write <= 1'b0;
      r_data_ph <= ~r_data_ph & w_ok;
      if (r_data_ph) begin
        r_cnt <= w_last ? 5'd0 : r_cnt + 5'd1;
        if (w_tx) r_out <= {r_out[239:0], 8'h00};
        if (r_state == S_GET_N) o_core_n <= {o_core_n[247:0], avm_readdata[7:0]};
        if (r_state == S_GET_D) o_core_d <= {o_core_d[247:0], avm_readdata[7:0]};
        if (r_state == S_GET_A) o_core_a <= {o_core_a[247:0], avm_readdata[7:0]};
      end
    end else if (w_issue) begin
      avm_read    <= ~(r_data_ph & w_tx);
      avm_write   <= r_data_ph & w_tx;
      avm_address <= ~r_data_ph ? 5'(STATUS_BASE) : w_tx ? 5'(TX_BASE) : 5'(RX_BASE);
      if (r_data_ph & w_tx) avm_writedata <= {24'h0, r_out[247:240]};
    end else if (r_state == S_WAIT && i_core_finished) begin
      r_out       <= i_core_result[247:0];
      avm_read    <= 1'b1;
      avm_address <= 5'(STATUS_BASE);
    end
endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// tb_rsa_uart_wrapper: UART slave and RSA core models around the wrapper, with a transfer-level
// scoreboard of expected Avalon accesses plus literal checks of the loaded key/data.
module tb_rsa_uart_wrapper;
  localparam int RXDLY = 2;
  localparam logic [255:0] N1 = 256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
  localparam logic [255:0] D1 = 256'h20212223_24252627_28292A2B_2C2D2E2F_30313233_34353637_38393A3B_3C3D3E3F;
  localparam logic [255:0] N2 = 256'h40414243_44454647_48494A4B_4C4D4E4F_50515253_54555657_58595A5B_5C5D5E5F;
  localparam logic [255:0] D2 = 256'h60616263_64656667_68696A6B_6C6D6E6F_70717273_74757677_78797A7B_7C7D7E7F;
  localparam logic [255:0] RES1 = N1;
  localparam logic [255:0] RES2 = {8{32'hC0FFEE11}};

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] avm_address;
  logic avm_read, avm_write, o_core_start;
  logic [31:0] avm_readdata = 32'h0, avm_writedata;
  logic avm_waitrequest = 1'b0, i_core_finished = 1'b0;
  logic [255:0] o_core_a, o_core_d, o_core_n, i_core_result = '0;

  always #5 clk = ~clk;

  rsa_uart_wrapper dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d), .o_core_n(o_core_n),
    .i_core_result(i_core_result), .i_core_finished(i_core_finished)
  );

  logic       exp_wr   [4096];
  logic [4:0] exp_addr [4096];
  logic [7:0] exp_byte [4096];
  logic [7:0] rx_mem   [512];
  int exp_w = 0, rx_w = 0;

  int n_cmp_a = 0, n_bad_a = 0, n_cmp_b = 0, n_bad_b = 0;
  int exp_r = 0, rx_r = 0, rx_nr = RXDLY, tx_nr = 0, ws_left = 3, ws_cycles = 0;
  int rx_reads = 0, tx_cnt = 0, wr_total = 0, polls = 0, pre_tx_polls = -1;
  logic tx_armed = 1'b0, rx_ok, tx_ok;
  logic [31:0] first_tx = 32'h0, last_tx = 32'h0;
  logic p_req = 1'b0, p_wait = 1'b0, p_rd = 1'b0, p_wr = 1'b0, p_start = 1'b0;
  logic [4:0] p_addr = 5'h0;
  logic [31:0] p_wd = 32'h0;

  task automatic chk_a(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_cmp_a++;
    if (act !== want) begin
      n_bad_a++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic chk_b(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_cmp_b++;
    if (act !== want) begin
      n_bad_b++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input logic w, input logic [4:0] a, input logic [7:0] b);
    exp_wr[exp_w] = w;
    exp_addr[exp_w] = a;
    exp_byte[exp_w] = b;
    exp_w++;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_w] = b;
    rx_w++;
    repeat (RXDLY + 1) push_exp(1'b0, 5'd8, 8'h0);
    push_exp(1'b0, 5'd0, b);
  endtask

  task automatic push_tx(input logic [7:0] b, input int n_polls);
    repeat (n_polls) push_exp(1'b0, 5'd8, 8'h0);
    push_exp(1'b1, 5'd4, b);
  endtask

  // Compare process: protocol rules every cycle, and every completed transfer against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_r = exp_w;
      rx_r = rx_w;
      rx_nr = RXDLY;
      avm_waitrequest = 1'b0;
      avm_readdata = 32'h0;
      p_req = 1'b0;
      p_start = 1'b0;
    end else begin
      chk_a("rd_wr_exclusive", avm_read & avm_write, 0);
      if (p_req && p_wait)
        chk_a("hold_while_wait", {avm_read, avm_write, avm_address, avm_writedata}, {p_rd, p_wr, p_addr, p_wd});
      else if (p_req)
        chk_a("req_drop_after_xfer", avm_read | avm_write, 0);
      chk_a("start_single_cycle", p_start & o_core_start, 0);
      if (o_core_start && !tx_armed) begin
        tx_armed = 1'b1;
        tx_nr = 5;
      end
      avm_waitrequest = 1'b0;
      if (avm_read && avm_address == 5'd0 && rx_reads == 4 && ws_left > 0) begin
        avm_waitrequest = 1'b1;
        ws_left--;
        ws_cycles++;
      end else if (avm_read || avm_write) begin
        if (exp_r < exp_w) begin
          chk_a("xfer_kind_addr", {avm_write, avm_address}, {exp_wr[exp_r], exp_addr[exp_r]});
          if (avm_write) chk_a("tx_writedata", avm_writedata, {24'h0, exp_byte[exp_r]});
          exp_r++;
        end else
          chk_a("idle_xfer_is_poll", {avm_write, avm_address}, {1'b0, 5'd8});
        if (avm_read && avm_address == 5'd8) begin
          rx_ok = (rx_nr == 0) && (rx_r < rx_w);
          if (rx_nr > 0) rx_nr--;
          tx_ok = (tx_nr == 0);
          if (tx_nr > 0) tx_nr--;
          avm_readdata = {24'h0, rx_ok, tx_ok, 6'h0};
          polls++;
        end else if (avm_read) begin
          avm_readdata = {24'h0, (rx_r < rx_w) ? rx_mem[rx_r] : 8'h00};
          if (rx_r < rx_w) rx_r++;
          rx_reads++;
          rx_nr = RXDLY;
          polls = 0;
        end else begin
          tx_cnt++;
          wr_total++;
          if (tx_cnt == 1) begin
            first_tx = avm_writedata;
            pre_tx_polls = polls;
          end
          if (tx_cnt == 31) last_tx = avm_writedata;
          rx_nr = RXDLY;
          polls = 0;
        end
      end
      p_req = avm_read | avm_write;
      p_wait = avm_waitrequest;
      p_rd = avm_read;
      p_wr = avm_write;
      p_addr = avm_address;
      p_wd = avm_writedata;
      p_start = o_core_start;
    end
  end

  // RSA core model: finished 20 cycles after each start, plus one stray pulse during key load.
  int starts = 0, cd = 0, cyc = 0;
  always @(negedge clk) begin
    cyc++;
    i_core_finished = 1'b0;
    if (!rst_n) cd = 0;
    else if (o_core_start) begin
      starts++;
      cd = 20;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_core_finished = 1'b1;
        i_core_result = (starts == 1) ? RES1 : RES2;
      end
    end else if (cyc == 100) begin
      i_core_finished = 1'b1;
      i_core_result = '1;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk_b({tag, "_addr"}, avm_address, 5'd8);
    chk_b({tag, "_read"}, avm_read, 0);
    chk_b({tag, "_write"}, avm_write, 0);
    chk_b({tag, "_wdata"}, avm_writedata, 0);
    chk_b({tag, "_start"}, o_core_start, 0);
    chk_b({tag, "_core_a"}, o_core_a, 0);
    chk_b({tag, "_core_d"}, o_core_d, 0);
    chk_b({tag, "_core_n"}, o_core_n, 0);
  endtask

  initial begin
    logic [255:0] r;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    for (int k = 0; k < 64; k++) push_rx(8'(k));
    repeat (32) push_rx(8'hAA);
    r = RES1;
    for (int i = 0; i < 31; i++) push_tx(r[247-8*i -: 8], (i == 0) ? 6 : 1);
    repeat (32) push_rx(8'h55);
    r = RES2;
    for (int i = 0; i < 10; i++) push_tx(r[247-8*i -: 8], 1);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_b("release_read", avm_read, 1);
    chk_b("release_addr", avm_address, 5'd8);
    chk_b("release_write", avm_write, 0);
    for (int i = 0; i < 5000 && starts < 1; i++) begin @(negedge clk); #1; end
    chk_b("first_start_seen", starts, 1);
    chk_b("no_write_before_start", wr_total, 0);
    chk_b("key_n", o_core_n, N1);
    chk_b("key_d", o_core_d, D1);
    chk_b("cipher_a", o_core_a, {32{8'hAA}});
    chk_b("waitreq_cycles", ws_cycles, 3);
    for (int i = 0; i < 5000 && tx_cnt < 31; i++) begin @(negedge clk); #1; end
    chk_b("tx_count_31", tx_cnt, 31);
    chk_b("first_tx_byte", first_tx, 32'h01);
    chk_b("last_tx_byte", last_tx, 32'h1F);
    chk_b("tx_stall_polls", pre_tx_polls, 6);
    chk_b("one_start_pulse", starts, 1);
    for (int i = 0; i < 5000 && starts < 2; i++) begin @(negedge clk); #1; end
    chk_b("second_start_seen", starts, 2);
    chk_b("cipher_a2", o_core_a, {32{8'h55}});
    chk_b("key_n_kept", o_core_n, N1);
    chk_b("key_d_kept", o_core_d, D1);
    for (int i = 0; i < 5000 && tx_cnt < 41; i++) begin @(negedge clk); #1; end
    chk_b("tx_count_41", tx_cnt, 41);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midsend_reset");
    repeat (2) @(negedge clk);
    #1;
    for (int k = 64; k < 128; k++) push_rx(8'(k));
    rst_n = 1'b1;
    for (int i = 0; i < 5000 && rx_r < rx_w; i++) begin @(negedge clk); #1; end
    chk_b("reload_consumed", rx_r, rx_w);
    repeat (2) @(negedge clk);
    #1;
    chk_b("reload_n", o_core_n, N2);
    chk_b("reload_d", o_core_d, D2);
    chk_b("no_extra_writes", tx_cnt, 41);
    chk_b("all_expected_seen", exp_r, exp_w);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp_a + n_cmp_b, n_bad_a + n_bad_b);
    $finish;
  end
endmodule

// File: doc/rsa_uart_wrapper.md
# rsa_uart_wrapper

- Avalon-MM master that connects the RSA256 decryption core to the RS232 UART peripheral.
- Operating loop:
  1. Once after reset, polls the UART and collects the 256-bit modulus n and private key d.
  2. Collects a 256-bit ciphertext block.
  3. Pulses the core start, waits for the core to finish, streams the 248-bit plaintext back out through the UART.
  4. Repeats from step 2 with the same key.
- Sits in the top level between the UART Avalon slave and the RSA core.

## Interface
Parameters:
- RX_BASE, 0, UART receive-data register address
- TX_BASE, 4, UART transmit-data register address
- STATUS_BASE, 8, UART status register address
- RX_OK_BIT, 7, status bit meaning "RX byte available"
- TX_OK_BIT, 6, status bit meaning "TX ready"

Ports:
- i_clk  in  1  clock. One clock domain; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low
- avm_address  out  5  Avalon byte address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data; only bits [7:0] are used
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data, formatted as {24'b0, byte}
- avm_waitrequest  in  1  slave stall
- o_core_start  out  1  single-cycle start pulse to the RSA core
- o_core_a  out  256  ciphertext
- o_core_d  out  256  private key
- o_core_n  out  256  modulus
- i_core_result  in  256  core result a^d mod n
- i_core_finished  in  1  single-cycle core done pulse

## Operation
- States:
  - S_GET_N, S_GET_D, S_GET_A: receive a 256-bit value.
  - S_START: issue the core start.
  - S_WAIT: wait for the core.
  - S_SEND: transmit the result.
- Byte transfer (every byte) has two phases:
  - Poll phase: read STATUS_BASE.
    - Receive states require readdata[RX_OK_BIT]=1; send state requires readdata[TX_OK_BIT]=1.
    - If the bit is clear, re-issue the status read.
  - Data phase:
    - Receive states: read RX_BASE.
    - S_SEND: write TX_BASE.
- Receive shifting: each received byte is shifted in at the LSB end, reg <= {reg[247:0], readdata[7:0]}, so the first byte becomes the MSB.
  - S_GET_N fills o_core_n; S_GET_D fills o_core_d; S_GET_A fills o_core_a.
  - Each receive state takes exactly 32 bytes; a 5-bit byte counter wraps 31 -> 0 on state exit.
- S_START:
  - o_core_start=1 for exactly one cycle.
  - o_core_a, o_core_d and o_core_n are stable from this cycle until S_SEND exits.
  - Next state: S_WAIT.
- S_WAIT:
  - No Avalon traffic.
  - On i_core_finished=1, latch i_core_result[247:0] into the output shift register, then go to S_SEND.
  - i_core_finished is ignored in every other state.
- S_SEND:
  - Sends 31 bytes, MSB first; writedata = {24'b0, out[247:240]}.
  - out is shifted left by 8 after each accepted write.
  - After byte 31, next state is S_GET_A; the key is not re-read.
- Bits [255:248] of the result are never transmitted.

## Timing
- Reset values (asynchronous, while i_rst_n=0):
  - avm_address=STATUS_BASE, avm_read=0, avm_write=0, avm_writedata=0, o_core_start=0.
  - o_core_a, o_core_d, o_core_n = 0; state = S_GET_N; byte counter = 0.
- First rising edge after reset release: avm_read=1, avm_address=STATUS_BASE.
- Avalon requests:
  - avm_read or avm_write, together with address and writedata, are held stable while avm_waitrequest=1.
  - A transfer completes on the edge where the request is high and avm_waitrequest=0.
  - Read data is sampled on that same edge.
  - The request drops to 0 for at least one cycle after each completed transfer.
- avm_read and avm_write are never high in the same cycle.
- Minimum time per byte with zero waitrequest: 4 cycles (status read, idle, data transfer, idle).
- Core handshake:
  - o_core_start rises one cycle after the 32nd ciphertext byte is captured.
  - The first status poll of S_SEND is issued the cycle after i_core_finished is sampled.
- Reset asserted mid-operation: immediate return to reset values; any partial key or data is discarded and the next session begins at S_GET_N.

## Test plan
- Reset:
  - Hold i_rst_n=0 for 3 cycles -> all outputs at reset values.
  - Release -> next cycle shows avm_read=1, avm_address=8, avm_write=0.
- Key and data load:
  - UART model supplies bytes 0x00..0x1F, then 0x20..0x3F, then 0xAA x32, with RX_OK=0 for 2 polls before each byte.
  - Required: o_core_n=0x000102…1F, o_core_d=0x2021…3F, o_core_a=0xAA…AA.
  - Required: one o_core_start pulse, and zero avm_write beforehand.
- Waitrequest stretch:
  - Hold avm_waitrequest=1 for 3 cycles on an RX data read.
  - Required: address and avm_read stable throughout; exactly one byte shifted in.
- Compute and send:
  - Core model asserts i_core_finished 20 cycles after start with result 0x00_0102…1F (byte k = k-1).
  - Required: 31 writes to address 4 with writedata 0x01, 0x02, …, 0x1F in order.
  - Required: then status polls for RX_OK with no re-read of n or d.
- TX stall:
  - Hold TX_OK=0 for 5 polls before the 1st output byte.
  - Required: exactly 6 status reads and no write until TX_OK=1.
- Mid-send reset:
  - Assert i_rst_n=0 after the 10th output byte.
  - Required: outputs return to reset values immediately; the next 64 received bytes reload n and d.
